// File: rtl/lsu_axi_rd_if.sv
// LSU read channel bundle: AR request and R response beats.
// The slave modport is the responder side.
interface lsu_axi_rd_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64,
    parameter int ID_W   = 8
);
    logic [ID_W-1:0]   lsu_axi_arid;
    logic [ADDR_W-1:0] lsu_axi_araddr;
    logic [7:0]        lsu_axi_arlen;
    logic [2:0]        lsu_axi_arsize;
    logic [1:0]        lsu_axi_arburst;
    logic [2:0]        lsu_axi_arstr;
    logic [7:0]        lsu_axi_arnum;
    logic              lsu_axi_arvld;
    logic              axi_lsu_arrdy;
    logic [ID_W-1:0]   axi_lsu_rid;
    logic [DATA_W-1:0] axi_lsu_rdata;
    logic [1:0]        axi_lsu_rresp;
    logic              axi_lsu_rlast;
    logic              axi_lsu_rvld;
    logic              lsu_axi_rrdy;

    modport master (
        output lsu_axi_arid, lsu_axi_araddr, lsu_axi_arlen,
        output lsu_axi_arsize, lsu_axi_arburst, lsu_axi_arstr,
        output lsu_axi_arnum, lsu_axi_arvld, lsu_axi_rrdy,
        input  axi_lsu_arrdy, axi_lsu_rid, axi_lsu_rdata,
        input  axi_lsu_rresp, axi_lsu_rlast, axi_lsu_rvld
    );

    modport slave (
        input  lsu_axi_arid, lsu_axi_araddr, lsu_axi_arlen,
        input  lsu_axi_arsize, lsu_axi_arburst, lsu_axi_arstr,
        input  lsu_axi_arnum, lsu_axi_arvld, lsu_axi_rrdy,
        output axi_lsu_arrdy, axi_lsu_rid, axi_lsu_rdata,
        output axi_lsu_rresp, axi_lsu_rlast, axi_lsu_rvld
    );
endinterface

// File: rtl/lsu_axi_rd_slv.sv
// LSU read responder: strided multi-row SRAM reads returned as
// R beats through a 2-entry fall-through buffer.
module lsu_axi_rd_slv #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64,
    parameter int ID_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    lsu_axi_rd_if.slave       axi,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_DRAIN,
        S_ERR
    } state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   id_q;
    logic [7:0]        len_q, num_q;
    logic [2:0]        str_q;
    logic              fixed_q;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [7:0]        beat_q, beat_d;
    logic [7:0]        row_q, row_d;
    logic              done_q, done_d;
    logic              fl_q, fl_err_q, fl_last_q;
    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] dat_q [2];
    logic [1:0]        rsp_q [2];
    logic [1:0]        lst_q;

    logic              ar_hs, bad_req, last_beat;
    logic              issue, vld, pop, wr, wr_idx;
    logic              hd_last;
    logic [2:0]        room;
    logic [ADDR_W-1:0] step;
    logic [DATA_W-1:0] in_dat;
    logic [1:0]        in_rsp;

    assign ar_hs     = (state_q == S_IDLE) && axi.lsu_axi_arvld;
    assign bad_req   = (axi.lsu_axi_arsize != 3'd3)
                     || axi.lsu_axi_arburst[1];
    assign last_beat = (beat_q == len_q) && (row_q == num_q);
    assign step      = ADDR_W'(9'(len_q) + 9'd1) << str_q;

    // A beat returning from SRAM (or an error beat) is visible
    // at the R port in the same cycle it would be written.
    assign vld    = (cnt_q != 2'd0) || fl_q;
    assign pop    = vld && axi.lsu_axi_rrdy;
    assign room   = 3'(cnt_q) + 3'(fl_q) - 3'(pop);
    assign in_dat = fl_err_q ? '0 : mem_rd_data;
    assign in_rsp = fl_err_q ? 2'b10 : 2'b00;
    assign wr     = fl_q && !((cnt_q == 2'd0) && pop);
    assign wr_idx = cnt_q[0] & ~pop;
    assign cnt_d  = cnt_q + 2'(fl_q) - 2'(pop);

    assign hd_last = (cnt_q != 2'd0) ? lst_q[0]
                                     : (fl_q & fl_last_q);

    assign axi.axi_lsu_arrdy = (state_q == S_IDLE);
    assign axi.axi_lsu_rvld  = vld;
    assign axi.axi_lsu_rid   = id_q;
    assign axi.axi_lsu_rlast = hd_last;
    assign axi.axi_lsu_rdata =
        (cnt_q != 2'd0) ? dat_q[0] : (fl_q ? in_dat : '0);
    assign axi.axi_lsu_rresp =
        (cnt_q != 2'd0) ? rsp_q[0] : (fl_q ? in_rsp : 2'b00);

    assign mem_rd_addr = fixed_q ? base_q
                                 : base_q + ADDR_W'(beat_q);

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        beat_d    = beat_q;
        row_d     = row_q;
        done_d    = done_q;
        issue     = 1'b0;
        mem_rd_en = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (ar_hs) begin
                    state_d = bad_req ? S_ERR : S_RD;
                    base_d  = axi.lsu_axi_araddr;
                    beat_d  = '0;
                    row_d   = '0;
                    done_d  = 1'b0;
                end
            end
            S_RD: begin
                issue     = room < 3'd2;
                mem_rd_en = issue;
                if (issue && last_beat)
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (pop && hd_last)
                    state_d = S_IDLE;
            end
            S_ERR: begin
                issue = !done_q && (room < 3'd2);
                if (issue && last_beat)
                    done_d = 1'b1;
                if (pop && hd_last)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (issue) begin
            if (beat_q == len_q) begin
                beat_d = '0;
                row_d  = row_q + 8'd1;
                base_d = base_q + step;
            end else begin
                beat_d = beat_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            id_q      <= '0;
            len_q     <= '0;
            num_q     <= '0;
            str_q     <= '0;
            fixed_q   <= 1'b0;
            base_q    <= '0;
            beat_q    <= '0;
            row_q     <= '0;
            done_q    <= 1'b0;
            fl_q      <= 1'b0;
            fl_err_q  <= 1'b0;
            fl_last_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            beat_q    <= beat_d;
            row_q     <= row_d;
            done_q    <= done_d;
            fl_q      <= issue;
            fl_err_q  <= (state_q == S_ERR);
            fl_last_q <= last_beat;
            if (ar_hs) begin
                id_q    <= axi.lsu_axi_arid;
                len_q   <= axi.lsu_axi_arlen;
                num_q   <= axi.lsu_axi_arnum;
                str_q   <= axi.lsu_axi_arstr;
                fixed_q <= ~axi.lsu_axi_arburst[0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            dat_q[0] <= '0;
            dat_q[1] <= '0;
            rsp_q[0] <= '0;
            rsp_q[1] <= '0;
            lst_q    <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (pop) begin
                dat_q[0] <= dat_q[1];
                rsp_q[0] <= rsp_q[1];
                lst_q[0] <= lst_q[1];
            end
            if (wr) begin
                dat_q[wr_idx] <= in_dat;
                rsp_q[wr_idx] <= in_rsp;
                lst_q[wr_idx] <= fl_last_q;
            end
        end
    end

endmodule
